pwm_carrier_event_gen: RTL and testbench

//  Triangle PWM-carrier generator and event source for the scheduler timing manager.

---
 rtl/pwm_carrier_event_gen.sv | 143 ++++++++++++++
 tb/tb_pwm_carrier_event_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_carrier_event_gen.sv
// Triangle PWM carrier generator with peak/valley pulses and a mode-selected event qualifier.
// Latency: carrier and peak/valley/shadow_load are registered (1 clk); event_qualifier is combinational from them.
// Backpressure: none; free-running when enabled, parked at 0 when disabled.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   enable_i              1 = carrier runs, 0 = carrier parked at 0 counting up
//   carrier_max_i         requested peak value, shadowed (values below 2 are treated as 2)
//   carrier_div_i         requested prescale, carrier steps every (div+1) clks, shadowed
//   event_mode_i          bit0 qualifies valleys, bit1 qualifies peaks
//   sync_i                restart carrier at 0 counting up (ignored while disabled)
//   carrier_o             current carrier count
//   carrier_dir_o         1 = counting up, 0 = counting down
//   peak_o / valley_o     1-clk pulses coinciding with carrier showing max / 0
//   event_qualifier_o     (peak & mode[1]) | (valley & mode[0])
//   shadow_load_o         1-clk pulse the cycle after the shadow max/div registers reload
module pwm_carrier_event_gen #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] carrier_max_i,
    input  logic [DIV_W-1:0] carrier_div_i,
    input  logic [1:0]       event_mode_i,
    input  logic             sync_i,
    output logic [CNT_W-1:0] carrier_o,
    output logic             carrier_dir_o,
    output logic             peak_o,
    output logic             valley_o,
    output logic             event_qualifier_o,
    output logic             shadow_load_o
);

    localparam logic [CNT_W-1:0] MAX_FLOOR = CNT_W'(2);

    logic [CNT_W-1:0] carrier_q, carrier_d;
    logic             dir_q, dir_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] max_sh_q, max_sh_d;
    logic [DIV_W-1:0] div_sh_q, div_sh_d;
    logic             peak_q, peak_d;
    logic             valley_q, valley_d;
    logic             shadow_load_q, shadow_load_d;
    logic             enable_q;

    logic             en_rise;
    logic             sync_go;
    logic [DIV_W-1:0] div_eff;
    logic             tick;
    logic [CNT_W-1:0] car_up;
    logic [CNT_W-1:0] car_dn;
    logic             valley_tick;
    logic             load;
    logic [CNT_W-1:0] max_clamped;

    assign en_rise     = enable_i & ~enable_q;
    assign sync_go     = enable_i & sync_i;
    // On the enable rising edge the freshly requested divider already governs
    // the first prescale interval, so the first step lands div+1 clks later.
    assign div_eff     = en_rise ? carrier_div_i : div_sh_q;
    // A sync restart takes priority over a coincident step.
    assign tick        = enable_i & ~sync_go & (presc_q == div_eff);
    assign car_up      = carrier_q + CNT_W'(1);
    assign car_dn      = carrier_q - CNT_W'(1);
    assign valley_tick = tick & ~dir_q & (car_dn == '0);
    // Shadows only change at a period boundary, so a running half-cycle
    // always completes with the max/div it started with.
    assign load        = en_rise | sync_go | valley_tick;
    assign max_clamped = (carrier_max_i < MAX_FLOOR) ? MAX_FLOOR : carrier_max_i;

    always_comb begin
        carrier_d     = carrier_q;
        dir_d         = dir_q;
        presc_d       = presc_q;
        max_sh_d      = max_sh_q;
        div_sh_d      = div_sh_q;
        peak_d        = 1'b0;
        valley_d      = 1'b0;
        shadow_load_d = load;

        if (!enable_i || sync_go) begin
            carrier_d = '0;
            dir_d     = 1'b1;
            presc_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            if (dir_q) begin
                carrier_d = car_up;
                if (car_up == max_sh_q) begin
                    dir_d  = 1'b0;
                    peak_d = 1'b1;
                end
            end else begin
                carrier_d = car_dn;
                if (car_dn == '0) begin
                    dir_d    = 1'b1;
                    valley_d = 1'b1;
                end
            end
        end else begin
            presc_d = presc_q + DIV_W'(1);
        end

        if (load) begin
            max_sh_d = max_clamped;
            div_sh_d = carrier_div_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            carrier_q     <= '0;
            dir_q         <= 1'b1;
            presc_q       <= '0;
            max_sh_q      <= MAX_FLOOR;
            div_sh_q      <= '0;
            peak_q        <= 1'b0;
            valley_q      <= 1'b0;
            shadow_load_q <= 1'b0;
            enable_q      <= 1'b0;
        end else begin
            carrier_q     <= carrier_d;
            dir_q         <= dir_d;
            presc_q       <= presc_d;
            max_sh_q      <= max_sh_d;
            div_sh_q      <= div_sh_d;
            peak_q        <= peak_d;
            valley_q      <= valley_d;
            shadow_load_q <= shadow_load_d;
            enable_q      <= enable_i;
        end
    end

    assign carrier_o         = carrier_q;
    assign carrier_dir_o     = dir_q;
    assign peak_o            = peak_q;
    assign valley_o          = valley_q;
    assign event_qualifier_o = (peak_q & event_mode_i[1]) | (valley_q & event_mode_i[0]);
    assign shadow_load_o     = shadow_load_q;

endmodule

// File: tb/tb_pwm_carrier_event_gen.sv
// Bench for pwm_carrier_event_gen: table-driven vectors plus corner-case sequences.
// Expected outputs are queued when each vector is driven and compared after the clock edge.
// Watchdog terminates the run if it ever stalls.
module tb_pwm_carrier_event_gen;

    typedef struct packed {
        logic [15:0] car;
        logic        dir;
        logic        pk;
        logic        vl;
        logic        eq;
        logic        sl;
    } exp_t;

    typedef struct {
        logic        en;
        logic        sy;
        logic [15:0] mx;
        logic [7:0]  dv;
        logic [1:0]  md;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] carrier_max = 16'd4;
    logic [7:0]  carrier_div = 8'd0;
    logic [1:0]  event_mode = 2'b11;
    logic        sync_in = 1'b0;
    logic [15:0] carrier;
    logic        carrier_dir, peak, valley, event_qualifier, shadow_load;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];
    exp_t exp_q[$];

    pwm_carrier_event_gen #(.CNT_W(16), .DIV_W(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .carrier_max_i    (carrier_max),
        .carrier_div_i    (carrier_div),
        .event_mode_i     (event_mode),
        .sync_i           (sync_in),
        .carrier_o        (carrier),
        .carrier_dir_o    (carrier_dir),
        .peak_o           (peak),
        .valley_o         (valley),
        .event_qualifier_o(event_qualifier),
        .shadow_load_o    (shadow_load)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input int car, input logic dr, pk, vl, eq, sl);
        exp_t e;
        e.car = 16'(car);
        e.dir = dr;
        e.pk  = pk;
        e.vl  = vl;
        e.eq  = eq;
        e.sl  = sl;
        return e;
    endfunction

    function automatic void add(input logic en, sy, input int mx, dv, input logic [1:0] md,
                                input int car, input logic dr, pk, vl, eq, sl);
        vec_t v;
        v.en = en;
        v.sy = sy;
        v.mx = 16'(mx);
        v.dv = 8'(dv);
        v.md = md;
        v.e  = mk(car, dr, pk, vl, eq, sl);
        tbl.push_back(v);
    endfunction

    task automatic compare(input string nm, input exp_t e);
        exp_t a;
        a = {carrier, carrier_dir, peak, valley, event_qualifier, shadow_load};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got carrier=%0d dir=%b pk=%b vl=%b eq=%b sl=%b, expected carrier=%0d dir=%b pk=%b vl=%b eq=%b sl=%b",
                     nm, a.car, a.dir, a.pk, a.vl, a.eq, a.sl, e.car, e.dir, e.pk, e.vl, e.eq, e.sl);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
    task automatic apply(input string nm, input logic en, sy, input int mx, dv, input logic [1:0] md,
                         input int car, input logic dr, pk, vl, eq, sl);
        exp_t e;
        @(negedge clk);
        enable      = en;
        sync_in     = sy;
        carrier_max = 16'(mx);
        carrier_div = 8'(dv);
        event_mode  = md;
        exp_q.push_back(mk(car, dr, pk, vl, eq, sl));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, expected an entry", nm);
        end else begin
            e = exp_q.pop_front();
            compare(nm, e);
        end
    endtask

    initial begin
        // en sy mx dv md   car dir pk vl eq sl
        add(0, 0, 4, 0, 2'b11, 0, 1, 0, 0, 0, 0);
        add(0, 0, 4, 0, 2'b11, 0, 1, 0, 0, 0, 0);
        // div 0, max 4, both edges qualified: period 8 clks
        add(1, 0, 4, 0, 2'b11, 1, 1, 0, 0, 0, 1);
        add(1, 0, 4, 0, 2'b11, 2, 1, 0, 0, 0, 0);
        add(1, 0, 4, 0, 2'b11, 3, 1, 0, 0, 0, 0);
        add(1, 0, 4, 0, 2'b11, 4, 0, 1, 0, 1, 0);
        add(1, 0, 4, 0, 2'b11, 3, 0, 0, 0, 0, 0);
        add(1, 0, 4, 0, 2'b11, 2, 0, 0, 0, 0, 0);
        add(1, 0, 4, 0, 2'b11, 1, 0, 0, 0, 0, 0);
        add(1, 0, 4, 0, 2'b11, 0, 1, 0, 1, 1, 1);
        add(1, 0, 4, 0, 2'b11, 1, 1, 0, 0, 0, 0);
        add(1, 0, 4, 0, 2'b11, 2, 1, 0, 0, 0, 0);
        add(1, 0, 4, 0, 2'b11, 3, 1, 0, 0, 0, 0);
        add(1, 0, 4, 0, 2'b11, 4, 0, 1, 0, 1, 0);
        // request div 2, max 3, peaks only: takes effect after the next valley
        add(1, 0, 3, 2, 2'b10, 3, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 2, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 1, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 0, 1, 0, 1, 0, 1);
        add(1, 0, 3, 2, 2'b10, 0, 1, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 0, 1, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 1, 1, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 1, 1, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 1, 1, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 2, 1, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 2, 1, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 2, 1, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 3, 0, 1, 0, 1, 0);
        add(1, 0, 3, 2, 2'b10, 3, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 3, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 2, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 2, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 2, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 1, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 1, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 1, 0, 0, 0, 0, 0);
        add(1, 0, 3, 2, 2'b10, 0, 1, 0, 1, 0, 1);

        // Reset state, held across a clock edge.
        @(posedge clk);
        #1;
        compare("reset_state", mk(0, 1, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("tbl%0d", i), tbl[i].en, tbl[i].sy, tbl[i].mx, tbl[i].dv, tbl[i].md,
                  int'(tbl[i].e.car), tbl[i].e.dir, tbl[i].e.pk, tbl[i].e.vl, tbl[i].e.eq, tbl[i].e.sl);
        end

        // Sync restart, then raise max mid up-count: current period still peaks at 4.
        apply("sync_a",    1, 1, 4, 0, 2'b11, 0, 1, 0, 0, 0, 1);
        apply("mx_up1",    1, 0, 4, 0, 2'b11, 1, 1, 0, 0, 0, 0);
        apply("mx_up2",    1, 0, 4, 0, 2'b11, 2, 1, 0, 0, 0, 0);
        apply("mx_chg3",   1, 0, 6, 0, 2'b11, 3, 1, 0, 0, 0, 0);
        apply("mx_old_pk", 1, 0, 6, 0, 2'b11, 4, 0, 1, 0, 1, 0);
        apply("mx_dn3",    1, 0, 6, 0, 2'b11, 3, 0, 0, 0, 0, 0);
        apply("mx_dn2",    1, 0, 6, 0, 2'b11, 2, 0, 0, 0, 0, 0);
        apply("mx_dn1",    1, 0, 6, 0, 2'b11, 1, 0, 0, 0, 0, 0);
        apply("mx_valley", 1, 0, 6, 0, 2'b11, 0, 1, 0, 1, 1, 1);
        for (int c = 1; c <= 5; c++)
            apply($sformatf("mx_new_up%0d", c), 1, 0, 6, 0, 2'b11, c, 1, 0, 0, 0, 0);
        apply("mx_new_pk", 1, 0, 6, 0, 2'b11, 6, 0, 1, 0, 1, 0);
        apply("mx_dn5",    1, 0, 6, 0, 2'b11, 5, 0, 0, 0, 0, 0);
        apply("mx_dn4",    1, 0, 6, 0, 2'b11, 4, 0, 0, 0, 0, 0);
        apply("mx_dn3b",   1, 0, 6, 0, 2'b11, 3, 0, 0, 0, 0, 0);
        // Sync while down-counting at 3: back to 0 counting up, no valley pulse.
        apply("sync_dn",   1, 1, 6, 0, 2'b11, 0, 1, 0, 0, 0, 1);

        // Max below 2 clamps to 2; mode 00 never qualifies.
        apply("clamp_sync", 1, 1, 1, 0, 2'b00, 0, 1, 0, 0, 0, 1);
        apply("clamp_1",    1, 0, 1, 0, 2'b00, 1, 1, 0, 0, 0, 0);
        apply("clamp_pk",   1, 0, 1, 0, 2'b00, 2, 0, 1, 0, 0, 0);
        apply("clamp_dn",   1, 0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        apply("clamp_vl",   1, 0, 1, 0, 2'b00, 0, 1, 0, 1, 0, 1);
        apply("clamp_up",   1, 0, 1, 0, 2'b00, 1, 1, 0, 0, 0, 0);

        // Disabled: parked at 0, sync ignored; re-enable with div 1.
        apply("dis_sync",  0, 1, 4, 1, 2'b11, 0, 1, 0, 0, 0, 0);
        apply("dis_hold",  0, 0, 4, 1, 2'b11, 0, 1, 0, 0, 0, 0);
        apply("en_rise",   1, 0, 4, 1, 2'b11, 0, 1, 0, 0, 0, 1);
        apply("en_tick1",  1, 0, 4, 1, 2'b11, 1, 1, 0, 0, 0, 0);
        apply("en_hold1",  1, 0, 4, 1, 2'b11, 1, 1, 0, 0, 0, 0);
        apply("en_tick2",  1, 0, 4, 1, 2'b11, 2, 1, 0, 0, 0, 0);

        // Async reset at carrier 5.
        apply("rs_sync",   1, 1, 6, 0, 2'b11, 0, 1, 0, 0, 0, 1);
        for (int c = 1; c <= 5; c++)
            apply($sformatf("rs_up%0d", c), 1, 0, 6, 0, 2'b11, c, 1, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        compare("rst_async", mk(0, 1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        compare("rst_held", mk(0, 1, 0, 0, 0, 0));
        rst = 1'b0;
        apply("rs_restart", 1, 0, 6, 0, 2'b11, 1, 1, 0, 0, 0, 1);
        for (int c = 2; c <= 5; c++)
            apply($sformatf("rs_re_up%0d", c), 1, 0, 6, 0, 2'b11, c, 1, 0, 0, 0, 0);
        apply("rs_re_pk",  1, 0, 6, 0, 2'b11, 6, 0, 1, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
